// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a programmable pattern and don't-care mask.
// Counts matches with a saturating counter; overlap mode is selectable.
module seq_pattern_detector #(
  parameter int PAT_LEN = 4,
  parameter int COUNT_W = 8,
  parameter logic [PAT_LEN-1:0] RESET_PATTERN =
    PAT_LEN'(4'b1011)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               seq_in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [PAT_LEN-1:0] cfg_mask,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               detect_out,
  output logic [COUNT_W-1:0] match_count
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-1:0] mask;
  logic [PAT_LEN-1:0] nh;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      nf;
  logic               overlap;
  logic               accept;
  logic               hit;

  // A cfg_load edge swallows the incoming bit.
  always_comb begin
    accept = in_valid & ~cfg_load;
    nh     = {hist[PAT_LEN-2:0], seq_in};
    nf     = (fill == FULL) ? fill : fill + 1'b1;
    hit    = accept && (nf == FULL) &&
             (((nh ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= RESET_PATTERN;
      mask    <= '1;
      overlap <= 1'b0;
    end else if (cfg_load) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= cfg_pattern;
      mask    <= cfg_mask;
      overlap <= cfg_overlap;
    end else if (accept) begin
      hist <= nh;
      fill <= (hit && !overlap) ? '0 : nf;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      detect_out  <= 1'b0;
      match_count <= '0;
    end else begin
      detect_out <= hit;
      if (count_clr)
        match_count <= '0;
      else if (hit && !(&match_count))
        match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector.
// Second instance uses COUNT_W=2 to exercise counter saturation.
module tb_seq_pattern_detector;

  logic       clk;
  logic       reset_n;
  logic       seq_in;
  logic       in_valid;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [3:0] cfg_mask;
  logic       cfg_overlap;
  logic       count_clr;
  logic       detect_out;
  logic [7:0] match_count;
  logic       detect2;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;

  seq_pattern_detector dut (
    .clk(clk), .reset_n(reset_n),
    .seq_in(seq_in), .in_valid(in_valid),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap),
    .count_clr(count_clr),
    .detect_out(detect_out),
    .match_count(match_count)
  );

  seq_pattern_detector #(.COUNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .seq_in(seq_in), .in_valid(in_valid),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap),
    .count_clr(count_clr),
    .detect_out(detect2),
    .match_count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b,
                        input logic v);
    seq_in   = b;
    in_valid = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [3:0] p,
                      input logic [3:0] m,
                      input logic o);
    cfg_pattern = p;
    cfg_mask    = m;
    cfg_overlap = o;
    cfg_load    = 1'b1;
    count_clr   = 1'b1;
    seq_in      = 1'b1;
    in_valid    = 1'b1;
    tick();
    cfg_load  = 1'b0;
    count_clr = 1'b0;
    in_valid  = 1'b0;
  endtask

  logic [6:0] s7;
  logic [6:0] e7;

  initial begin
    reset_n     = 1'b0;
    seq_in      = 1'b0;
    in_valid    = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 4'b0000;
    cfg_mask    = 4'b0000;
    cfg_overlap = 1'b0;
    count_clr   = 1'b0;
    tick();
    tick();
    chk("rst_det", 32'(detect_out), 32'd0);
    chk("rst_cnt", 32'(match_count), 32'd0);
    chk("rst_cnt2", 32'(count2), 32'd0);
    reset_n = 1'b1;
    tick();

    // reset pattern 1011
    bit_in(1'b1, 1'b1);
    chk("t1_b1", 32'(detect_out), 32'd0);
    bit_in(1'b0, 1'b1);
    chk("t1_b2", 32'(detect_out), 32'd0);
    bit_in(1'b1, 1'b1);
    chk("t1_b3", 32'(detect_out), 32'd0);
    bit_in(1'b1, 1'b1);
    chk("t1_det", 32'(detect_out), 32'd1);
    chk("t1_cnt", 32'(match_count), 32'd1);
    tick();
    chk("t1_pulse", 32'(detect_out), 32'd0);
    chk("t1_cnt_hold", 32'(match_count), 32'd1);

    // non-overlap, stream 1011011
    load(4'b1011, 4'b1111, 1'b0);
    chk("load_no_det", 32'(detect_out), 32'd0);
    chk("load_clr", 32'(match_count), 32'd0);
    s7 = 7'b1011011;
    e7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      bit_in(s7[i], 1'b1);
      chk($sformatf("novl_b%0d", 7 - i),
          32'(detect_out), 32'(e7[i]));
    end
    chk("novl_cnt", 32'(match_count), 32'd1);

    // overlap, stream 1011011
    load(4'b1011, 4'b1111, 1'b1);
    e7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      bit_in(s7[i], 1'b1);
      chk($sformatf("ovl_b%0d", 7 - i),
          32'(detect_out), 32'(e7[i]));
    end
    chk("ovl_cnt", 32'(match_count), 32'd2);

    // valid gaps of 3 cycles
    load(4'b1011, 4'b1111, 1'b0);
    s7 = 7'b0001011;
    for (int i = 3; i >= 0; i--) begin
      bit_in(s7[i], 1'b1);
      chk($sformatf("gap_b%0d", 4 - i),
          32'(detect_out), (i == 0) ? 32'd1 : 32'd0);
      for (int g = 0; g < 3; g++) begin
        bit_in(1'b0, 1'b0);
        chk($sformatf("gap_idle%0d_%0d", 4 - i, g),
            32'(detect_out), 32'd0);
      end
    end
    chk("gap_cnt", 32'(match_count), 32'd1);

    // masked pattern 1100/1110 with reload after 3 bits
    load(4'b1100, 4'b1110, 1'b0);
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    load(4'b1100, 4'b1110, 1'b0);
    bit_in(1'b1, 1'b1);
    chk("refill_b1", 32'(detect_out), 32'd0);
    bit_in(1'b1, 1'b1);
    chk("refill_b2", 32'(detect_out), 32'd0);
    bit_in(1'b0, 1'b1);
    chk("refill_b3", 32'(detect_out), 32'd0);
    bit_in(1'b1, 1'b1);
    chk("mask_det", 32'(detect_out), 32'd1);
    chk("mask_cnt", 32'(match_count), 32'd1);

    // saturation on the 2-bit counter
    load(4'b1111, 4'b1111, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      bit_in(1'b1, 1'b1);
      chk($sformatf("sat_b%0d", i),
          32'(detect_out), (i >= 4) ? 32'd1 : 32'd0);
    end
    chk("sat_cnt8", 32'(match_count), 32'd6);
    chk("sat_cnt2", 32'(count2), 32'd3);
    count_clr = 1'b1;
    bit_in(1'b1, 1'b1);
    count_clr = 1'b0;
    chk("clr_hit_det", 32'(detect_out), 32'd1);
    chk("clr_hit_cnt", 32'(match_count), 32'd0);
    chk("clr_hit_cnt2", 32'(count2), 32'd0);

    // reset mid-match
    load(4'b1011, 4'b1111, 1'b0);
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_det", 32'(detect_out), 32'd0);
    chk("mid_rst_cnt", 32'(match_count), 32'd0);
    tick();
    reset_n = 1'b1;
    bit_in(1'b1, 1'b1);
    chk("post_rst_last", 32'(detect_out), 32'd0);
    bit_in(1'b1, 1'b1);
    bit_in(1'b0, 1'b1);
    bit_in(1'b1, 1'b1);
    chk("post_rst_b3", 32'(detect_out), 32'd0);
    bit_in(1'b1, 1'b1);
    chk("post_rst_det", 32'(detect_out), 32'd1);
    chk("post_rst_cnt", 32'(match_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
